huffman_encoder: RTL
====================

Name: huffman_encoder

Overview:
- Transmit-side counterpart of the Huffman decoder wrapper that feeds xmem.
- Accepts parallel activation words of col*bw bits from a producer such as an SRAM reader or testbench driver.
- Encodes each bw-bit lane with the team's fixed prefix code and emits a serial MSB-first bitstream.
- The bitstream is directly consumable by the decoder's serial data input and valid input.

Parameters:
- col, 8, number of lanes per word
- bw, 8, bits per lane/symbol
- addr_bw, 11, width of word address counter

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_data  input  col*bw  word to encode; lane k = in_data[bw*k+bw-1 : bw*k]
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  encoder can accept a word this cycle
- bit_ready  input  1  consumer accepts bit_out this cycle; tie high for the decoder
- bit_out  output  1  current serial bit
- bit_valid  output  1  bit_out is meaningful
- word_done  output  1  one-cycle pulse when the last bit of a word is accepted
- word_addr  output  addr_bw  index of the word currently being sent

Behaviour:
- Code table, per symbol s, bits sent left to right:
  - s == 0 -> "0" (length 1)
  - s == 1 -> "10" (length 2)
  - any other value -> "11" followed by s[bw-1:0] MSB-first (length bw+2)
- Lane order within a word: lane 0 first, lane col-1 last.
- States:
  - IDLE: in_ready=1, bit_valid=0. A transfer occurs when in_valid && in_ready. On transfer, latch in_data, set lane=0, load the code/len of lane 0, go to EMIT.
  - EMIT: bit_valid=1, bit_out = MSB of the code shift register.
    - Advance only when bit_ready=1: shift left and decrement the remaining count.
    - When the last bit of a lane is accepted and lane < col-1: increment lane, load the next code. There are no bubbles between lanes.
    - When the last bit of lane col-1 is accepted: pulse word_done and increment word_addr (wrap 2^addr_bw-1 -> 0).
      - If in_valid=1 that same cycle, accept the next word directly (in_ready=1 only in that cycle) and stay in EMIT.
      - Otherwise go to IDLE.
- Latency: the first bit appears on the cycle after the accepting edge. A word takes sum(len) cycles at bit_ready=1. Range is col cycles (all zero) to col*(bw+2) cycles.
- bit_ready=0 holds bit_out, the shift register, the lane index and word_addr unchanged. bit_valid stays 1.
- in_data is ignored outside accept cycles; the producer may change it freely.
- Reset values (asynchronous, reset=0): state=IDLE, in_ready=1, bit_out=0, bit_valid=0, word_done=0, word_addr=0, lane=0, shift register=0.
- Reset asserted mid-word abandons the word immediately with no partial completion. The consumer sees bit_valid drop in the same cycle.
- Simultaneous last-bit accept and new-word accept: word_done pulses and word_addr increments. The first bit of the new word is driven on the next cycle.

Optional Feature:
- Macro HUFF_STATS_EN.
- Defined:
  - Adds output bit_count [15:0], incremented on every accepted bit and saturating at 16'hFFFF.
  - Adds output word_count [15:0], incremented on every word_done and saturating.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package huffman_pkg holds:
  - state enum {IDLE, EMIT}
  - code constants CODE_ZERO=1'b0, CODE_ONE=2'b10, PREFIX_LIT=2'b11
  - length constants LEN_ZERO=1, LEN_ONE=2, LEN_LIT=bw+2
  - the same constants are used by the decoder
- One combinational sub-module, huffman_sym_coder:
  - inputs: symbol [bw-1:0]
  - outputs: code [bw+1:0], left-aligned; len [3:0]
  - instantiated once, fed by a lane mux.

Test Plan:
- All-zero word, bit_ready=1 -> 8 bits of 0; word_done at cycle 8; in_ready high again in IDLE; word_addr 0->1.
- Word 64'h0101010101010101 -> pattern "10" ×8, 16 bits; word_done at cycle 16.
- Word 64'h00000000000000A5 -> 1,1,1,0,1,0,0,1,0,1 then seven 0s; 17 bits.
- Same A5 word, bit_ready=0 for 3 cycles after the 4th bit -> bit_out holds 0 and bit_valid stays 1; total 20 cycles; bitstream unchanged.
- Back-to-back words with in_valid held, then 2048 all-zero words -> no idle cycle between words; word_addr wraps 2047->0.
- reset=0 in the middle of a literal, then release -> all outputs at reset values; the next word encodes from lane 0; loop the bitstream into the decoder and compare the decoded word against the source.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared Huffman code constants and encoder state type.
package huffman_pkg;

  localparam int COL     = 8;
  localparam int BW      = 8;
  localparam int ADDR_BW = 11;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  localparam logic       CODE_ZERO  = 1'b0;
  localparam logic [1:0] CODE_ONE   = 2'b10;
  localparam logic [1:0] PREFIX_LIT = 2'b11;

  localparam logic [3:0] LEN_ZERO = 4'd1;
  localparam logic [3:0] LEN_ONE  = 4'd2;
  localparam logic [3:0] LEN_LIT  = 4'(BW + 2);

endpackage

// File: rtl/huffman_sym_coder.sv
// Maps one symbol to its left-aligned prefix code and length.
module huffman_sym_coder
  import huffman_pkg::*;
#(
  parameter int bw = BW
) (
  input  logic [bw-1:0] symbol,
  output logic [bw+1:0] code,
  output logic [3:0]    len
);

  always_comb begin
    code = '0;
    len  = 4'(bw + 2);
    unique case (1'b1)
      (symbol == '0): begin
        code[bw+1] = CODE_ZERO;
        len        = LEN_ZERO;
      end
      (symbol == bw'(1)): begin
        code[bw+1:bw] = CODE_ONE;
        len           = LEN_ONE;
      end
      default: begin
        code = {PREFIX_LIT, symbol};
        len  = 4'(bw + 2);
      end
    endcase
  end

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: word of col lanes in, MSB-first bitstream out.
// HUFF_STATS_EN adds saturating bit_count / word_count outputs.
module huffman_encoder
  import huffman_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw      = BW,
  parameter int addr_bw = ADDR_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [col*bw-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               bit_ready,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               word_done,
  output logic [addr_bw-1:0] word_addr
`ifdef HUFF_STATS_EN
  ,
  output logic [15:0]        bit_count,
  output logic [15:0]        word_count
`endif
);

  localparam int LW = (col > 1) ? $clog2(col) : 1;
  localparam int CW = bw + 2;
  localparam logic [LW-1:0] LAST_LANE = LW'(col - 1);

  state_e             state_q, state_d;
  logic [col*bw-1:0]  data_q, data_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [CW-1:0]      shift_q, shift_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [addr_bw-1:0] addr_q, addr_d;

  logic [LW-1:0] lane_inc;
  logic [bw-1:0] sym;
  logic [CW-1:0] code;
  logic [3:0]    len;
  logic          last_bit;
  logic          last_word;
  logic          accept;

  huffman_sym_coder #(.bw(bw)) u_coder (
    .symbol (sym),
    .code   (code),
    .len    (len)
  );

  always_comb begin
    lane_inc  = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
    last_bit  = (state_q == EMIT) && bit_ready && (cnt_q == 4'd1);
    last_word = last_bit && (lane_q == LAST_LANE);
    in_ready  = (state_q == IDLE) || last_word;
    accept    = in_valid && in_ready;
    // The one coder serves lane 0 of a new word or the next lane
    sym = accept ? in_data[bw-1:0] : data_q[lane_inc*bw +: bw];
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          lane_d  = '0;
          shift_d = code;
          cnt_d   = len;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bit_ready) begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - 1'b1;
        end
        if (last_bit && !last_word) begin
          lane_d  = lane_inc;
          shift_d = code;
          cnt_d   = len;
        end
        if (last_word) begin
          addr_d = addr_q + 1'b1;
          if (accept) begin
            data_d  = in_data;
            lane_d  = '0;
            shift_d = code;
            cnt_d   = len;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      lane_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign bit_valid = (state_q == EMIT);
  assign bit_out   = bit_valid & shift_q[CW-1];
  assign word_done = last_word;
  assign word_addr = addr_q;

`ifdef HUFF_STATS_EN
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (bit_valid && bit_ready && bit_cnt_q != 16'hFFFF)
      bit_cnt_d = bit_cnt_q + 16'd1;
    if (last_word && word_cnt_q != 16'hFFFF)
      word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bit_count  = bit_cnt_q;
  assign word_count = word_cnt_q;
`endif

endmodule
